// File: rtl/mesi_event_gen_pkg.sv
// Shared codes for the MESI event generator: line states, bus messages,
// emitter/listener event codes and the request FSM states.
package mesi_pkg;

    typedef enum logic [2:0] {
        LS_I = 3'b001,
        LS_S = 3'b010,
        LS_E = 3'b011,
        LS_M = 3'b100
    } line_state_e;

    localparam logic [2:0] MSG_RD_MISS = 3'b001;
    localparam logic [2:0] MSG_WR_MISS = 3'b010;
    localparam logic [2:0] MSG_INV     = 3'b100;

    localparam logic [4:0] EV_NONE       = 5'b00000;
    localparam logic [4:0] EV_RD_MISS    = 5'b00001;
    localparam logic [4:0] EV_RD_HIT     = 5'b00010;
    localparam logic [4:0] EV_WR_MISS    = 5'b00100;
    localparam logic [4:0] EV_WR_HIT     = 5'b01000;
    localparam logic [4:0] EV_RD_MISS_SH = 5'b10001;

    localparam logic [4:0] EV_SNP_RD  = 5'b00001;
    localparam logic [4:0] EV_SNP_WR  = 5'b00100;
    localparam logic [4:0] EV_SNP_INV = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_ISSUE
    } fsm_e;

    function automatic logic [4:0] emitter_event(input logic we, input logic hit,
                                                 input logic shared);
        if (we)
            return hit ? EV_WR_HIT : EV_WR_MISS;
        else if (hit)
            return EV_RD_HIT;
        else
            return shared ? EV_RD_MISS_SH : EV_RD_MISS;
    endfunction

    function automatic logic [4:0] listener_event(input logic [2:0] msg);
        case (msg)
            MSG_RD_MISS: return EV_SNP_RD;
            MSG_WR_MISS: return EV_SNP_WR;
            MSG_INV:     return EV_SNP_INV;
            default:     return EV_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mesi_event_gen_if.sv
// Request/snoop/event bundle between requesters, the event generator and
// the per-line MESI blocks.
interface mesi_event_gen_if #(
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 2
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ack;
    logic              snp_req;
    logic [2:0]        snp_msg;
    logic [ADDR_W-1:0] snp_addr;
    logic              snp_ack;
    logic              shared_in;
    logic [2:0]        line_state;
    logic [IDX_W-1:0]  line_idx;
    logic              Controle;
    logic [4:0]        CPU_event;
    logic              busy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, snp_req, snp_msg, snp_addr,
               shared_in, line_state,
        input  cpu_ack, snp_ack, line_idx, Controle, CPU_event, busy
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, snp_req, snp_msg, snp_addr,
               shared_in, line_state,
        output cpu_ack, snp_ack, line_idx, Controle, CPU_event, busy
    );
endinterface

// File: rtl/mesi_event_gen_tag_array.sv
// Direct-mapped tag directory: combinational read, one synchronous write
// port, synchronous clear.
module mesi_tag_array #(
    parameter int IDX_W = 2,
    parameter int TAG_W = 6
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [TAG_W-1:0] wtag,
    input  logic [IDX_W-1:0] ridx,
    output logic [TAG_W-1:0] rtag
);
    localparam int NUM_LINES = 2**IDX_W;

    logic [TAG_W-1:0] tags [NUM_LINES];

    always_ff @(posedge CLK) begin
        if (CLR)
            tags <= '{default: '0};
        else if (we)
            tags[widx] <= wtag;
    end

    assign rtag = tags[ridx];
endmodule

// File: rtl/mesi_event_gen.sv
// Serialising front-end: accepts one CPU request or snoop at a time, looks up
// the tag directory and issues a single-cycle event to the addressed line.
module mesi_event_gen
    import mesi_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 2
) (
    input logic             CLK,
    input logic             CLR,
    mesi_event_gen_if.slave bus
);
    localparam int TAG_W = ADDR_W - IDX_W;

    fsm_e             state_q, state_d;
    logic             accept_snp, accept_cpu;
    logic             src_cpu_q, we_q, hit_q;
    logic [2:0]       msg_q;
    logic [TAG_W-1:0] tag_q, dir_tag;
    logic [IDX_W-1:0] idx_q;
    logic [4:0]       ev_q, ev_w;
    logic             hit_w, tag_we;

    mesi_tag_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_tags (
        .CLK  (CLK),
        .CLR  (CLR),
        .we   (tag_we),
        .widx (idx_q),
        .wtag (tag_q),
        .ridx (idx_q),
        .rtag (dir_tag)
    );

    always_ff @(posedge CLK) begin
        if (CLR)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        accept_snp    = 1'b0;
        accept_cpu    = 1'b0;
        bus.cpu_ack   = 1'b0;
        bus.snp_ack   = 1'b0;
        bus.Controle  = 1'b0;
        bus.CPU_event = EV_NONE;
        case (state_q)
            S_IDLE: begin
                // Snoops take priority; a simultaneous CPU request stays pending.
                if (bus.snp_req) begin
                    accept_snp = 1'b1;
                    state_d    = S_LOOKUP;
                end else if (bus.cpu_req) begin
                    accept_cpu = 1'b1;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_ISSUE;
            S_ISSUE: begin
                bus.CPU_event = ev_q;
                bus.Controle  = src_cpu_q;
                bus.cpu_ack   = src_cpu_q;
                bus.snp_ack   = ~src_cpu_q;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign hit_w = (dir_tag == tag_q) && (bus.line_state != LS_I);
    assign ev_w  = src_cpu_q ? emitter_event(we_q, hit_w, bus.shared_in)
                             : (hit_w ? listener_event(msg_q) : EV_NONE);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            src_cpu_q <= 1'b0;
            we_q      <= 1'b0;
            msg_q     <= '0;
            tag_q     <= '0;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            ev_q      <= '0;
        end else begin
            if (accept_snp) begin
                src_cpu_q <= 1'b0;
                we_q      <= 1'b0;
                msg_q     <= bus.snp_msg;
                tag_q     <= bus.snp_addr[ADDR_W-1:IDX_W];
                idx_q     <= bus.snp_addr[IDX_W-1:0];
            end else if (accept_cpu) begin
                src_cpu_q <= 1'b1;
                we_q      <= bus.cpu_we;
                msg_q     <= '0;
                tag_q     <= bus.cpu_addr[ADDR_W-1:IDX_W];
                idx_q     <= bus.cpu_addr[IDX_W-1:0];
            end
            if (state_q == S_LOOKUP) begin
                hit_q <= hit_w;
                ev_q  <= ev_w;
            end
        end
    end

    // CPU misses allocate the line by overwriting its tag as the event issues.
    assign tag_we = (state_q == S_ISSUE) && src_cpu_q && !hit_q;

    assign bus.line_idx = idx_q;
    assign bus.busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_mesi_event_gen.sv
// Scoreboard bench for mesi_event_gen: directed cases plus random traffic
// against a tag-directory reference model.
module tb_mesi_event_gen;

    logic CLK = 1'b0;
    logic CLR = 1'b1;
    always #5 CLK = ~CLK;

    mesi_event_gen_if #(.ADDR_W(8), .IDX_W(2)) bus ();

    mesi_event_gen #(.ADDR_W(8), .IDX_W(2)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    typedef struct {
        bit         is_cpu;
        logic [4:0] ev;
        logic [1:0] idx;
    } exp_t;

    exp_t       exp_q[$];
    logic [5:0] tag_m   [4];
    logic [2:0] line_st [4];
    int         vectors     = 0;
    int         miscompares = 0;
    bit         mon_en      = 0;

    // Each MESI block reports the state of whichever line is selected.
    assign bus.line_state = line_st[bus.line_idx];

    always @(negedge CLK) begin
        exp_t e;
        if (mon_en) begin
            vectors++;
            if (bus.cpu_ack || bus.snp_ack) begin
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_ack: got cpu_ack=%0b snp_ack=%0b event=%05b, required no ack",
                             bus.cpu_ack, bus.snp_ack, bus.CPU_event);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.cpu_ack !== e.is_cpu || bus.snp_ack !== !e.is_cpu ||
                        bus.Controle !== e.is_cpu || bus.CPU_event !== e.ev ||
                        bus.line_idx !== e.idx) begin
                        miscompares++;
                        $display("FAIL issue: got cpu_ack=%0b snp_ack=%0b Controle=%0b event=%05b idx=%0d, required cpu_ack=%0b snp_ack=%0b Controle=%0b event=%05b idx=%0d",
                                 bus.cpu_ack, bus.snp_ack, bus.Controle, bus.CPU_event, bus.line_idx,
                                 e.is_cpu, !e.is_cpu, e.is_cpu, e.ev, e.idx);
                    end
                end
            end else if (bus.Controle !== 1'b0 || bus.CPU_event !== 5'b0) begin
                miscompares++;
                $display("FAIL idle_outputs: got Controle=%0b event=%05b, required 0 and 00000",
                         bus.Controle, bus.CPU_event);
            end
        end
    end

    function automatic bit model_hit(input logic [7:0] addr, input logic [2:0] lst);
        return (tag_m[addr[1:0]] == addr[7:2]) && (lst != 3'b001);
    endfunction

    task automatic push_cpu(input bit we, input logic [7:0] addr, input logic [2:0] lst,
                            input bit shr);
        exp_t e;
        bit   hit;
        hit      = model_hit(addr, lst);
        e.is_cpu = 1'b1;
        e.idx    = addr[1:0];
        if (we)       e.ev = hit ? 5'b01000 : 5'b00100;
        else if (hit) e.ev = 5'b00010;
        else          e.ev = shr ? 5'b10001 : 5'b00001;
        if (!hit) tag_m[addr[1:0]] = addr[7:2];
        exp_q.push_back(e);
    endtask

    task automatic push_snp(input logic [2:0] msg, input logic [7:0] addr,
                            input logic [2:0] lst);
        exp_t e;
        e.is_cpu = 1'b0;
        e.idx    = addr[1:0];
        e.ev     = 5'b0;
        if (model_hit(addr, lst)) begin
            if (msg == 3'b001)      e.ev = 5'b00001;
            else if (msg == 3'b010) e.ev = 5'b00100;
            else if (msg == 3'b100) e.ev = 5'b10000;
        end
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input bit is_cpu);
        int n;
        for (n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (is_cpu ? bus.cpu_ack : bus.snp_ack) break;
        end
        if (n == 20) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: got no %s ack within 20 cycles, required one",
                     is_cpu ? "cpu" : "snp");
        end else begin
            @(posedge CLK);
        end
        #1;
        if (is_cpu) bus.cpu_req = 1'b0;
        else        bus.snp_req = 1'b0;
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic run_txn(input bit s_en, input bit c_en, input logic [2:0] msg,
                           input logic [7:0] saddr, input bit we, input logic [7:0] caddr,
                           input logic [2:0] lst, input bit shr);
        if (s_en) line_st[saddr[1:0]] = lst;
        if (c_en) line_st[caddr[1:0]] = lst;
        bus.shared_in = shr;
        if (s_en) push_snp(msg, saddr, lst);
        if (c_en) push_cpu(we, caddr, lst, shr);
        bus.snp_msg  = msg;
        bus.snp_addr = saddr;
        bus.cpu_we   = we;
        bus.cpu_addr = caddr;
        bus.snp_req  = s_en;
        bus.cpu_req  = c_en;
        fork
            if (s_en) wait_ack(1'b0);
            if (c_en) wait_ack(1'b1);
        join
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit         s_en, c_en, we, shr;
        logic [2:0] msg, lst;
        logic [1:0] si, ci;
        logic [5:0] st, ct;

        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0;
        bus.snp_req = 0; bus.snp_msg = '0; bus.snp_addr = '0;
        bus.shared_in = 0;
        for (int i = 0; i < 4; i++) begin
            tag_m[i]   = '0;
            line_st[i] = 3'b001;
        end

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (bus.busy !== 1'b0 || bus.cpu_ack !== 1'b0 || bus.snp_ack !== 1'b0 ||
            bus.Controle !== 1'b0 || bus.CPU_event !== 5'b0 || bus.line_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%0b acks=%0b%0b Controle=%0b event=%05b idx=%0d, required all 0",
                     bus.busy, bus.cpu_ack, bus.snp_ack, bus.Controle, bus.CPU_event, bus.line_idx);
        end
        @(posedge CLK);
        #1 CLR = 1'b0;
        mon_en = 1'b1;

        // Directed cases
        run_txn(0, 1, 3'b000, 8'h00, 0, 8'h45, 3'b001, 0);   // read miss
        run_txn(0, 1, 3'b000, 8'h00, 0, 8'h45, 3'b001, 1);   // read miss, shared
        run_txn(0, 1, 3'b000, 8'h00, 1, 8'h45, 3'b011, 0);   // write hit
        run_txn(0, 1, 3'b000, 8'h00, 1, 8'h85, 3'b011, 0);   // write miss, tag 0x21
        run_txn(0, 1, 3'b000, 8'h00, 0, 8'h45, 3'b001, 0);   // back to tag 0x11
        run_txn(1, 0, 3'b010, 8'h45, 0, 8'h00, 3'b100, 0);   // snoop write-miss hit
        run_txn(1, 0, 3'b100, 8'hC5, 0, 8'h00, 3'b100, 0);   // snoop tag mismatch
        run_txn(1, 1, 3'b001, 8'h45, 0, 8'h85, 3'b100, 1);   // simultaneous

        // Clear during LOOKUP with the CPU request held; tag[1] is 0x21 here.
        line_st[1] = 3'b010;
        bus.shared_in = 0;
        bus.cpu_we = 0;
        bus.cpu_addr = 8'h01;
        bus.cpu_req = 1;
        @(posedge CLK);
        #1 CLR = 1'b1;
        @(posedge CLK);
        #1 CLR = 1'b0;
        for (int i = 0; i < 4; i++) tag_m[i] = '0;
        @(negedge CLK);
        vectors++;
        if (bus.busy !== 1'b0 || bus.CPU_event !== 5'b0 || bus.cpu_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_in_lookup: got busy=%0b event=%05b cpu_ack=%0b, required 0",
                     bus.busy, bus.CPU_event, bus.cpu_ack);
        end
        push_cpu(0, 8'h01, 3'b010, 0);
        wait_ack(1'b1);

        // Random traffic
        for (int t = 0; t < 250; t++) begin
            s_en = ($urandom_range(0, 4) == 0);
            c_en = s_en ? 1'b1 : 1'b0;
            if (!s_en) begin
                s_en = $urandom_range(0, 1);
                c_en = !s_en;
            end
            si  = 2'($urandom_range(0, 3));
            ci  = 2'($urandom_range(0, 3));
            st  = $urandom_range(0, 1) ? tag_m[si] : 6'($urandom);
            ct  = $urandom_range(0, 1) ? tag_m[ci] : 6'($urandom);
            case ($urandom_range(0, 4))
                0:       msg = 3'b001;
                1:       msg = 3'b010;
                2:       msg = 3'b100;
                default: msg = 3'($urandom);
            endcase
            lst = 3'($urandom_range(1, 4));
            we  = $urandom_range(0, 1);
            shr = $urandom_range(0, 1);
            run_txn(s_en, c_en, msg, {st, si}, we, {ct, ci}, lst, shr);
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
        end

        repeat (5) @(negedge CLK);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: got %0d unissued expected events, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mesi_event_gen.md
Name: mesi_event_gen

Overview:
- Upstream front-end for the per-line MESI state blocks: accepts CPU requests and bus snoops, does a tag lookup on a small direct-mapped directory, and produces the one-cycle `CPU_event` code plus the `Controle` emitter/listener select for the addressed line.
- Owns the tag directory.
- Line state is read back from the selected line's MESI block through `line_state`.
- Serialises all traffic: one request in flight.

Parameters:
- `ADDR_W`, default 8: address width.
- `IDX_W`, default 2: index width; `NUM_LINES` = 2**`IDX_W`.
- `TAG_W`, default `ADDR_W`-`IDX_W`: derived, not overridable.

Ports:
- `CLK`  in  1  clock; all logic on rising edge.
- `CLR`  in  1  reset, synchronous, active-high.
- `cpu_req`  in  1  CPU request; level, held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  `ADDR_W`  index = low `IDX_W` bits, tag = upper bits.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `snp_req`  in  1  snoop request; level, held until `snp_ack`.
- `snp_msg`  in  3  bus message: 001 read miss, 010 write miss, 100 invalidate.
- `snp_addr`  in  `ADDR_W`  snoop address.
- `snp_ack`  out  1  one-cycle completion pulse.
- `shared_in`  in  1  another cache holds the line.
- `line_state`  in  3  state of line at `line_idx`: 001 I, 010 S, 011 E, 100 M.
- `line_idx`  out  `IDX_W`  selected line.
- `Controle`  out  1  1 = emitter (CPU), 0 = listener (snoop).
- `CPU_event`  out  5  event to the selected MESI block; 0 = no action.
- `busy`  out  1  high when not IDLE.

Behaviour:
- Reset: synchronous `CLR` → IDLE. All outputs 0. All tags 0. Any in-flight request is dropped with no ack and no event. Applies from any state.
- FSM states: IDLE → LOOKUP → ISSUE → IDLE.
- IDLE:
  - If `snp_req`, capture `snp_addr`/`snp_msg`, set src=SNP.
  - Else if `cpu_req`, capture `cpu_addr`/`cpu_we`, set src=CPU.
  - Then go LOOKUP. Snoop always wins a simultaneous request; CPU request stays pending.
- `line_idx`: registered at accept; held through LOOKUP and ISSUE; keeps its last value in IDLE.
- LOOKUP (1 cycle):
  - hit = (tag[idx] == captured tag) && (`line_state` != 001).
  - Register hit, `shared_in`, and the computed event.
- ISSUE (1 cycle):
  - Drive `CPU_event` (and `Controle` = 1 if src=CPU).
  - Pulse the matching ack.
  - Return to IDLE.
- Emitter events (src=CPU):
  - read hit → 00010.
  - read miss → 00001, or 10001 if `shared_in` sampled 1.
  - write hit → 01000.
  - write miss → 00100.
  - On any miss, write the captured tag into tag[idx] at the ISSUE edge.
- Listener events (src=SNP, hit only):
  - msg 001 → 00001.
  - msg 010 → 00100.
  - msg 100 → 10000.
  - Other msg codes, or a miss: `CPU_event` = 0; ack still pulses. No tag write.
- Outside ISSUE: `CPU_event` = 0 and `Controle` = 0, so downstream blocks see no action.
- Latency: request accepted at edge T0 → event and ack during cycle T0+2. The requester drops req on the edge where ack is seen. A req still high in IDLE is treated as a new request.
- Throughput: one request per 3 cycles.
- `busy` = (state != IDLE).

Decomposition:
- `mesi_pkg`: state codes (I/S/E/M), emitter and listener event codes, bus message codes, FSM state enum.
- Sub-module `mesi_tag_array`: `NUM_LINES` x `TAG_W`, combinational read, single synchronous write port, synchronous clear on `CLR`.

Test Plan:
- After `CLR`: CPU read 0x45 (idx 1, tag 0x11), `line_state`=001, `shared_in`=0 → two cycles after accept: `Controle`=1, `CPU_event`=00001, `line_idx`=1, `cpu_ack`=1 for one cycle; tag[1]=0x11 afterwards.
- Same request with `shared_in`=1 → `CPU_event`=10001; next cycle `CPU_event`=0, `Controle`=0.
- tag[1]=0x11, `line_state`=011, CPU write 0x45 → `CPU_event`=01000, tag unchanged. CPU write 0x85 (tag 0x21, idx 1) → 00100, tag[1]=0x21.
- tag[1]=0x11, `line_state`=100:
  - snoop msg 010 addr 0x45 → `Controle`=0, `CPU_event`=00100, `snp_ack` pulse.
  - snoop msg 100 addr 0xC5 (mismatch) → `CPU_event`=0, `snp_ack` pulse.
- `snp_req` and `cpu_req` asserted in the same cycle → snoop event at T0+2. CPU accepted at T0+3, event at T0+5. `cpu_ack` never coincides with `snp_ack`.
- `CLR` during LOOKUP → next cycle IDLE, `busy`=0, no ack, no event, all tags 0. A held `cpu_req` is re-accepted after `CLR` drops.
